// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: a single full adder processes one bit per clock, LSB first,
// with a registered carry. Operands arrive on a valid/ready request port; {cout, sum} leave on a
// valid/ready result port.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             done_valid_q, done_valid_d;
    logic             busy_q, busy_d;
    logic             start_ready_q, start_ready_d;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d       = state_q;
        a_sr_d        = a_sr_q;
        b_sr_d        = b_sr_q;
        sum_sr_d      = sum_sr_q;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        c_d           = c_q;
        cout_d        = cout_q;
        done_valid_d  = done_valid_q;
        busy_d        = busy_q;
        start_ready_d = start_ready_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sr_d        = a;
                    b_sr_d        = b;
                    c_d           = cin;
                    sum_sr_d      = '0;
                    cnt_d         = '0;
                    state_d       = RUN;
                    busy_d        = 1'b1;
                    start_ready_d = 1'b0;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                c_d      = fa_co;
                // Counter holds on the final bit rather than wrapping.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d        = {fa_s, sum_sr_q[WIDTH-1:1]};
                    cout_d       = fa_co;
                    done_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_d  = 1'b0;
                    busy_d        = 1'b0;
                    start_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                done_valid_d  = 1'b0;
                busy_d        = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_sr_q        <= '0;
            b_sr_q        <= '0;
            sum_sr_q      <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            c_q           <= 1'b0;
            cout_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            a_sr_q        <= a_sr_d;
            b_sr_q        <= b_sr_d;
            sum_sr_q      <= sum_sr_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            c_q           <= c_d;
            cout_q        <= cout_d;
            done_valid_q  <= done_valid_d;
            busy_q        <= busy_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign start_ready = start_ready_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign done_valid  = done_valid_q;
    assign busy        = busy_q;
endmodule
